lcd_spi_tx: RTL and testbench
=============================

LCD_SPI_TX -- requirements
Module: lcd_spi_tx

Interface
REQ-001 The block SHALL have parameter CLK_DIV, default 25, giving the sclk half-period in clk cycles (legal range 1..65535).
REQ-002 The block SHALL have parameter RST_CYCLES, default 1000, giving the clk cycles lcd_rst is held low and the settle wait after release (legal range 1..2^20-1).
REQ-003 clk  input  1  system clock; all state on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 data_in  input  8  byte to send, MSB first.
REQ-006 dc_in  input  1  data/command flag for the byte: 0 = command, 1 = display data.
REQ-007 start  input  1  transfer request, honoured only while ready=1.
REQ-008 ready  output  1  high when the block can accept start.
REQ-009 busy  output  1  high during the LCD reset sequence and any transfer.
REQ-010 avail  output  1  one-cycle pulse when a byte has fully shifted out.
REQ-011 mosi, sclk, cs, dc, lcd_rst  output  1 each  LCD serial data, serial clock, chip select (active-low), data/command line, LCD reset (active-low).

Function
REQ-012 The FSM SHALL have states RST_HOLD, RST_WAIT, IDLE, SETUP, SHIFT, DONE, GAP.
REQ-013 RST_HOLD: lcd_rst=0 for RST_CYCLES cycles, then RST_WAIT.
REQ-014 RST_WAIT: lcd_rst=1 for RST_CYCLES cycles, then IDLE; lcd_rst stays 1 until the next reset.
REQ-015 IDLE: ready=1, busy=0, cs=1, sclk=0; start=1 captures data_in and dc_in into registers, drives dc from dc_in, and enters SETUP on the next cycle.
REQ-016 start while ready=0 SHALL be ignored, with no queuing; changing data_in or dc_in after capture SHALL have no effect.
REQ-017 SETUP: cs=0, mosi=bit7, sclk=0 for CLK_DIV cycles, then SHIFT.
REQ-018 SHIFT: 8 bits, each sclk low for CLK_DIV cycles then high for CLK_DIV cycles (mode 0); mosi changes only on sclk falling edges, so 16*CLK_DIV cycles total.
REQ-019 DONE: one cycle with sclk=0 and avail=1, then GAP, or SETUP under REQ-027.
REQ-020 GAP: cs=1 for CLK_DIV cycles, then IDLE.
REQ-021 Latency from the start-capture edge to the avail pulse SHALL be exactly 17*CLK_DIV+1 cycles.
REQ-022 dc SHALL hold its captured value from capture until the next capture, including through GAP and IDLE.
REQ-023 The divider counter SHALL be 16 bits, the reset counter 20 bits, and the bit index 3 bits; counters reload on every state change with no wrap-around carry into the next state.

Reset
REQ-024 While reset=0, the outputs SHALL be mosi=0, sclk=0, cs=1, dc=0, lcd_rst=0, ready=0, busy=1, avail=0, and the state SHALL be RST_HOLD.
REQ-025 Reset asserted mid-transfer SHALL abort immediately with no avail pulse; after release the full RST_HOLD/RST_WAIT sequence SHALL rerun.

Configuration
REQ-026 The block SHALL have macro LCD_SPI_BURST_EN.
REQ-027 With LCD_SPI_BURST_EN defined: start=1 during DONE captures new data_in and dc_in, keeps cs=0, and goes directly to SETUP, so consecutive bytes have no cs gap and ready=1 during DONE.
REQ-028 Without LCD_SPI_BURST_EN: ready=0 in DONE, DONE always goes to GAP, and start in DONE is ignored.

Verification
REQ-029 Reset release with RST_CYCLES=4, CLK_DIV=2 -> lcd_rst low 4 cycles then high; ready rises 8 cycles after release; cs=1 and sclk=0 throughout.
REQ-030 start with data_in=8'hA5, dc_in=0 -> mosi samples 1,0,1,0,0,1,0,1 on 8 sclk rising edges; dc=0; avail pulses 35 cycles after capture; cs high 2 cycles after avail.
REQ-031 Repeated start during a transfer of 8'h0C -> transfer unaffected, only 8 sclk edges, exactly one avail pulse.
REQ-032 Reset asserted at bit 3 of 8'hFF -> outputs take reset values combinationally, no avail pulse, full reset sequence reruns after release.
REQ-033 With LCD_SPI_BURST_EN, starts of 8'h21 then 8'h90 held in DONE -> cs stays low across both bytes, 16 rising edges, two avail pulses 35 cycles apart.
REQ-034 Without LCD_SPI_BURST_EN, the same stimulus -> second start ignored, cs high for 2 cycles after the first byte, and a new start is required in IDLE.

Source files
------------

// File: rtl/lcd_spi_tx_if.sv
// lcd_spi_tx_if -- host-side handshake bundle for the LCD SPI transmitter.
//   data_in : byte to send, MSB first
//   dc_in   : data/command flag for that byte (0 = command, 1 = display data)
//   start   : transfer request, honoured only while ready is high
//   ready   : block can accept start this cycle
//   busy    : LCD reset sequence or a transfer is in progress
//   avail   : one-cycle pulse when a byte has fully shifted out
// master = host driving requests, slave = lcd_spi_tx.
interface lcd_spi_tx_if;
  logic [7:0] data_in;
  logic       dc_in;
  logic       start;
  logic       ready;
  logic       busy;
  logic       avail;

  modport master (output data_in, dc_in, start, input  ready, busy, avail);
  modport slave  (input  data_in, dc_in, start, output ready, busy, avail);
endinterface

// File: rtl/lcd_spi_tx.sv
// lcd_spi_tx -- write-only SPI (mode 0) byte transmitter for an LCD panel,
// with a power-on LCD reset sequence (lcd_rst low, then a settle wait).
//
// Parameters
//   CLK_DIV    : sclk half-period in clk cycles (1..65535)
//   RST_CYCLES : clk cycles lcd_rst is held low, and the settle wait after
//                release (1..2^20-1)
// Ports
//   clk     : system clock, all state on rising edge
//   reset   : asynchronous active-low reset
//   host    : lcd_spi_tx_if.slave (data_in, dc_in, start, ready, busy, avail)
//   mosi    : serial data, MSB first, changes on sclk falling edges
//   sclk    : serial clock, idles low
//   cs      : chip select, active low
//   dc      : data/command line, holds the last captured dc_in
//   lcd_rst : LCD reset, active low
// Build option
//   LCD_SPI_BURST_EN : when defined, a start seen in DONE captures the next
//                      byte and goes straight back to SETUP with cs kept low.
module lcd_spi_tx #(
  parameter int CLK_DIV    = 25,
  parameter int RST_CYCLES = 1000
) (
  input  logic         clk,
  input  logic         reset,
  lcd_spi_tx_if.slave  host,
  output logic         mosi,
  output logic         sclk,
  output logic         cs,
  output logic         dc,
  output logic         lcd_rst
);

`ifdef LCD_SPI_BURST_EN
  localparam bit BURST_EN = 1'b1;
`else
  localparam bit BURST_EN = 1'b0;
`endif

  localparam logic [15:0] DIV_LAST = 16'(CLK_DIV - 1);
  localparam logic [19:0] RST_LAST = 20'(RST_CYCLES - 1);

  typedef enum logic [2:0] {
    RST_HOLD,
    RST_WAIT,
    IDLE,
    SETUP,
    SHIFT,
    DONE,
    GAP
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] div_q, div_d;
  logic [19:0] rst_cnt_q, rst_cnt_d;
  logic [2:0]  bit_q, bit_d;
  logic        phase_q, phase_d;   // 0 = sclk low half, 1 = sclk high half
  logic [7:0]  sh_q, sh_d;         // sh_q[7] is the bit on mosi
  logic        dc_q, dc_d;

  logic div_end;
  logic rst_end;
  logic capture;

  assign div_end = (div_q == DIV_LAST);
  assign rst_end = (rst_cnt_q == RST_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= RST_HOLD;
      div_q     <= '0;
      rst_cnt_q <= '0;
      bit_q     <= '0;
      phase_q   <= 1'b0;
      sh_q      <= '0;
      dc_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      rst_cnt_q <= rst_cnt_d;
      bit_q     <= bit_d;
      phase_q   <= phase_d;
      sh_q      <= sh_d;
      dc_q      <= dc_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    div_d     = div_q;
    rst_cnt_d = rst_cnt_q;
    bit_d     = bit_q;
    phase_d   = phase_q;
    sh_d      = sh_q;
    dc_d      = dc_q;
    capture   = 1'b0;

    case (state_q)
      RST_HOLD: begin
        if (rst_end) state_d = RST_WAIT;
        else         rst_cnt_d = rst_cnt_q + 20'd1;
      end
      RST_WAIT: begin
        if (rst_end) state_d = IDLE;
        else         rst_cnt_d = rst_cnt_q + 20'd1;
      end
      IDLE: begin
        if (host.start) begin
          capture = 1'b1;
          state_d = SETUP;
        end
      end
      SETUP: begin
        if (div_end) state_d = SHIFT;
        else         div_d = div_q + 16'd1;
      end
      SHIFT: begin
        if (div_end) begin
          div_d = '0;
          if (!phase_q) begin
            phase_d = 1'b1;
          end else begin
            // Falling sclk edge: advance to the next bit or finish.
            phase_d = 1'b0;
            if (bit_q == 3'd7) begin
              state_d = DONE;
            end else begin
              bit_d = bit_q + 3'd1;
              sh_d  = {sh_q[6:0], 1'b0};
            end
          end
        end else begin
          div_d = div_q + 16'd1;
        end
      end
      DONE: begin
        if (BURST_EN && host.start) begin
          capture = 1'b1;
          state_d = SETUP;
        end else begin
          state_d = GAP;
        end
      end
      GAP: begin
        if (div_end) state_d = IDLE;
        else         div_d = div_q + 16'd1;
      end
      default: state_d = RST_HOLD;
    endcase

    if (capture) begin
      sh_d = host.data_in;
      dc_d = host.dc_in;
    end

    // Every state starts its timing from zero; nothing carries across.
    if (state_d != state_q) begin
      div_d     = '0;
      rst_cnt_d = '0;
      bit_d     = '0;
      phase_d   = 1'b0;
    end
  end

  // Outputs decode straight from registered state, so reset forces them
  // to their idle values without waiting for a clock.
  assign host.ready = (state_q == IDLE) || (BURST_EN && (state_q == DONE));
  assign host.busy  = (state_q != IDLE);
  assign host.avail = (state_q == DONE);
  assign sclk       = (state_q == SHIFT) && phase_q;
  assign cs         = !((state_q == SETUP) || (state_q == SHIFT) || (state_q == DONE));
  assign mosi       = ((state_q == SETUP) || (state_q == SHIFT)) ? sh_q[7] : 1'b0;
  assign dc         = dc_q;
  assign lcd_rst    = (state_q != RST_HOLD);

endmodule

// File: tb/tb_lcd_spi_tx.sv
// Directed bench for lcd_spi_tx with CLK_DIV=2, RST_CYCLES=4.
// Sampling is #1 after each rising clk edge; inputs change at the same point.
// Transfer timing for CLK_DIV=2, counting edges after the capture edge (c=0
// is the sample right after capture): SETUP c=0..1, SHIFT c=2..33,
// DONE c=34 (the 35th cycle after capture), GAP c=35..36, IDLE from c=37.
module tb_lcd_spi_tx;
  localparam int CLK_DIV    = 2;
  localparam int RST_CYCLES = 4;

  logic clk = 1'b0;
  logic reset;
  logic mosi, sclk, cs, dc, lcd_rst;

  lcd_spi_tx_if hif();

  lcd_spi_tx #(.CLK_DIV(CLK_DIV), .RST_CYCLES(RST_CYCLES)) dut (
    .clk     (clk),
    .reset   (reset),
    .host    (hif),
    .mosi    (mosi),
    .sclk    (sclk),
    .cs      (cs),
    .dc      (dc),
    .lcd_rst (lcd_rst)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [15:0] bits;
  int          rises;
  int          avails;
  logic        cs_h  [0:127];
  logic        av_h  [0:127];
  logic        rdy_h [0:127];
  logic        dc_h  [0:127];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int cs_highs(input int a, input int b);
    int n = 0;
    for (int i = a; i <= b; i++) if (cs_h[i]) n++;
    return n;
  endfunction

  // Post-release sequence: lcd_rst low for 4 edges, high after; ready on edge 8.
  task automatic rst_seq(input string pfx);
    for (int k = 1; k <= 8; k++) begin
      step();
      chk($sformatf("%s_lcd_rst_%0d", pfx, k), 32'(lcd_rst), 32'(k >= RST_CYCLES));
      chk($sformatf("%s_ready_%0d", pfx, k), 32'(hif.ready), 32'(k == 2*RST_CYCLES));
      chk($sformatf("%s_cs_%0d", pfx, k), 32'(cs), 32'd1);
      chk($sformatf("%s_sclk_%0d", pfx, k), 32'(sclk), 32'd0);
    end
  endtask

  // Capture byte d, then record ncyc+1 samples. Between samples lo..hi start
  // is raised with d2/dc2; otherwise start is low. data_in/dc_in are flipped
  // right after capture to show the captured copy is what gets sent.
  task automatic xfer(input logic [7:0] d, input logic dcv, input int ncyc,
                      input int lo, input int hi, input logic [7:0] d2, input logic dc2);
    logic prev_sclk;
    hif.start = 1'b1; hif.data_in = d; hif.dc_in = dcv;
    step();
    hif.start = 1'b0; hif.data_in = ~d; hif.dc_in = ~dcv;
    bits = '0; rises = 0; avails = 0; prev_sclk = 1'b0;
    for (int c = 0; c <= ncyc; c++) begin
      cs_h[c] = cs; av_h[c] = hif.avail; rdy_h[c] = hif.ready; dc_h[c] = dc;
      if (sclk && !prev_sclk) begin
        rises++;
        bits = {bits[14:0], mosi};
      end
      prev_sclk = sclk;
      if (hif.avail) avails++;
      if (c >= lo && c <= hi) begin
        hif.start = 1'b1; hif.data_in = d2; hif.dc_in = dc2;
      end else begin
        hif.start = 1'b0;
      end
      step();
    end
  endtask

  initial begin
    reset = 1'b0;
    hif.start = 1'b0; hif.data_in = 8'h00; hif.dc_in = 1'b0;

    // Held in reset
    step(); step(); step();
    chk("rst_mosi",    32'(mosi),      32'd0);
    chk("rst_sclk",    32'(sclk),      32'd0);
    chk("rst_cs",      32'(cs),        32'd1);
    chk("rst_dc",      32'(dc),        32'd0);
    chk("rst_lcd_rst", 32'(lcd_rst),   32'd0);
    chk("rst_ready",   32'(hif.ready), 32'd0);
    chk("rst_busy",    32'(hif.busy),  32'd1);
    chk("rst_avail",   32'(hif.avail), 32'd0);

    reset = 1'b1;
    rst_seq("boot");
    chk("idle_busy", 32'(hif.busy), 32'd0);

    // 8'hA5 as a command byte
    xfer(8'hA5, 1'b0, 40, -1, -2, 8'h00, 1'b0);
    chk("a5_bits",     32'(bits[7:0]), 32'hA5);
    chk("a5_rises",    32'(rises),     32'd8);
    chk("a5_avails",   32'(avails),    32'd1);
    chk("a5_av_c34",   32'(av_h[34]),  32'd1);
    chk("a5_cs_low",   32'(cs_highs(0, 34)), 32'd0);
    chk("a5_gap_cs0",  32'(cs_h[35]),  32'd1);
    chk("a5_gap_cs1",  32'(cs_h[36]),  32'd1);
    chk("a5_gap_rdy",  32'(rdy_h[36]), 32'd0);
    chk("a5_idle_rdy", 32'(rdy_h[37]), 32'd1);
    chk("a5_dc",       32'(dc_h[40]),  32'd0);

    // 8'h0C with start repeatedly raised mid-transfer
    xfer(8'h0C, 1'b1, 45, 3, 30, 8'hF0, 1'b0);
    chk("0c_bits",   32'(bits[7:0]), 32'h0C);
    chk("0c_rises",  32'(rises),     32'd8);
    chk("0c_avails", 32'(avails),    32'd1);
    chk("0c_dc",     32'(dc_h[45]),  32'd1);
    chk("0c_cs_end", 32'(cs_h[45]),  32'd1);

    // 8'h21 then 8'h90 with start held during DONE
    xfer(8'h21, 1'b1, 75, 34, 34, 8'h90, 1'b0);
`ifdef LCD_SPI_BURST_EN
    chk("bu_bits",    32'(bits),       32'h2190);
    chk("bu_rises",   32'(rises),      32'd16);
    chk("bu_avails",  32'(avails),     32'd2);
    chk("bu_av_c34",  32'(av_h[34]),   32'd1);
    chk("bu_av_c69",  32'(av_h[69]),   32'd1);
    chk("bu_cs_low",  32'(cs_highs(0, 69)), 32'd0);
    chk("bu_rdy_done",32'(rdy_h[34]),  32'd1);
    chk("bu_dc1",     32'(dc_h[34]),   32'd1);
    chk("bu_dc2",     32'(dc_h[40]),   32'd0);
    chk("bu_idle",    32'(rdy_h[72]),  32'd1);
`else
    chk("nb_bits",    32'(bits[7:0]),  32'h21);
    chk("nb_rises",   32'(rises),      32'd8);
    chk("nb_avails",  32'(avails),     32'd1);
    chk("nb_av_c34",  32'(av_h[34]),   32'd1);
    chk("nb_rdy_done",32'(rdy_h[34]),  32'd0);
    chk("nb_gap_cs0", 32'(cs_h[35]),   32'd1);
    chk("nb_gap_cs1", 32'(cs_h[36]),   32'd1);
    chk("nb_idle",    32'(rdy_h[37]),  32'd1);
    chk("nb_dc",      32'(dc_h[75]),   32'd1);
    chk("nb_cs_end",  32'(cs_h[75]),   32'd1);
`endif

    // 8'hFF aborted by reset during the high half of its fourth bit
    hif.start = 1'b1; hif.data_in = 8'hFF; hif.dc_in = 1'b1;
    step();
    hif.start = 1'b0;
    for (int c = 1; c <= 16; c++) step();
    chk("ab_pre_sclk", 32'(sclk), 32'd1);
    chk("ab_pre_mosi", 32'(mosi), 32'd1);
    reset = 1'b0;
    #1;
    chk("ab_mosi",    32'(mosi),      32'd0);
    chk("ab_sclk",    32'(sclk),      32'd0);
    chk("ab_cs",      32'(cs),        32'd1);
    chk("ab_dc",      32'(dc),        32'd0);
    chk("ab_lcd_rst", 32'(lcd_rst),   32'd0);
    chk("ab_ready",   32'(hif.ready), 32'd0);
    chk("ab_busy",    32'(hif.busy),  32'd1);
    chk("ab_avail",   32'(hif.avail), 32'd0);
    for (int k = 0; k < 3; k++) begin
      step();
      chk($sformatf("ab_avail_hold_%0d", k), 32'(hif.avail), 32'd0);
    end
    reset = 1'b1;
    rst_seq("rerun");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
